// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receive path. The asynchronous rx line is synchronised, then
//   sampled at mid-bit using a 16x oversampling tick whose phase is aligned
//   to the detected start edge. Good bytes are presented with a one-cycle
//   valid strobe; a low stop bit produces a one-cycle frame_err strobe.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   rx         in   serial line, asynchronous, idles high
//   data_out   out  [7:0] last correctly received byte
//   valid      out  one-cycle pulse when data_out updates
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high whenever the receiver is not idle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for rx_s low; divider held at 0
// START     | counting to mid start bit; high there means glitch, drop it
// DATA      | sampling 8 data bits, LSB first, every 16th tick
// STOP      | sampling the stop bit; strobe valid or frame_err
// WAIT_HIGH | after a framing error, wait for the line to return high

module uart_receiver #(
  parameter int clk_freq = 1_000_000,
  parameter int baud     = 9600,
  parameter int os_rate  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = clk_freq / (baud * os_rate);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV - 1);
  localparam logic [3:0]       HALF_TICK = 4'(os_rate / 2 - 1);
  localparam logic [3:0]       LAST_TICK = 4'(os_rate - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               r_rx_meta;
  logic               r_rx_s;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               w_os_tick;
  logic [3:0]         r_tick_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic [7:0]         r_data_out;
  logic               r_valid;
  logic               r_frame_err;

  logic               w_tick_clr;
  logic               w_tick_inc;
  logic               w_bit_clr;
  logic               w_bit_inc;
  logic               w_shift_en;
  logic               w_load;
  logic               w_ferr;

  // Reset asserts immediately but is released two clocks later, so every
  // flop below leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Held at 0 in IDLE so the first tick lands DIV cycles after the start edge.
  assign w_os_tick = (r_state != IDLE) && (r_div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)                          r_div_cnt <= '0;
    else if (r_state == IDLE || w_os_tick) r_div_cnt <= '0;
    else                                   r_div_cnt <= r_div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_tick_inc  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_tick_clr  = 1'b1;
          w_bit_clr   = 1'b1;
        end
      end
      START: begin
        if (w_os_tick) begin
          if (r_tick_cnt == HALF_TICK) begin
            w_tick_clr  = 1'b1;
            w_state_nxt = r_rx_s ? IDLE : DATA;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_os_tick) begin
          if (r_tick_cnt == LAST_TICK) begin
            w_tick_clr = 1'b1;
            w_shift_en = 1'b1;
            w_bit_inc  = 1'b1;
            if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_os_tick) begin
          if (r_tick_cnt == LAST_TICK) begin
            w_tick_clr = 1'b1;
            if (r_rx_s) begin
              w_load      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = WAIT_HIGH;
            end
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_data_out  <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_tick_clr)      r_tick_cnt <= 4'd0;
      else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + 4'd1;

      if (w_bit_clr)      r_bit_cnt <= 3'd0;
      else if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 3'd1;

      // LSB arrives first, so shifting right leaves bit 0 in place after 8 bits.
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};

      if (w_load) r_data_out <= r_shift;

      r_valid     <= w_load;
      r_frame_err <= w_ferr;
    end
  end

  assign data_out  = r_data_out;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_536_000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;  // 160

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_busy = 0;
  int n_overlap = 0;
  int n_long = 0;
  int valid_cyc = 0;
  logic [7:0] cap_last = 8'h00;
  logic [7:0] cap_prev = 8'h00;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;

  uart_receiver #(
    .clk_freq(CLK_FREQ),
    .baud    (BAUD),
    .os_rate (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      cap_prev = cap_last;
      cap_last = data_out;
      valid_cyc = cyc;
      if (prev_valid) n_long++;
    end
    if (frame_err) begin
      n_ferr++;
      if (prev_ferr) n_long++;
    end
    if (valid && frame_err) n_overlap++;
    if (busy) n_busy++;
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  task automatic drive_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    drive_bit(stop_b, BIT_CLKS);
  endtask

  // Stand-in for the team transmitter: serialises a 10-bit 8N1 word.
  task automatic tx_write(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0, f0, t0, lat;
    v0 = n_valid; f0 = n_ferr; t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (200) @(negedge clk);
    lat = valid_cyc - t0;
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d want 1", n_valid - v0); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data: got %h want a5", data_out); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL good_ferr_count: got %0d want 0", n_ferr - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after: got %b want 0", busy); end
    checks++; if (lat < 1515 || lat > 1535) begin errors++; $display("FAIL good_latency: got %0d want 1515..1535", lat); end
  endtask

  task automatic test_glitch();
    int v0, f0, b0, bt;
    v0 = n_valid; f0 = n_ferr; b0 = n_busy;
    drive_bit(1'b0, 30);
    drive_bit(1'b1, 200);
    bt = n_busy - b0;
    checks++; if (bt < 70 || bt > 95) begin errors++; $display("FAIL glitch_busy_cycles: got %0d want 70..95", bt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_valid_count: got %0d want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr_count: got %0d want 0", n_ferr - f0); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h want a5", data_out); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 400);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_valid_count: got %0d want 0", n_valid - v0); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h want a5", data_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b want 1", busy); end
    drive_bit(1'b1, 20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_restart: got %0d want 0", n_valid - v0); end
    drive_bit(1'b1, 100);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 100);
    checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0); end
    checks++; if (cap_prev !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", cap_prev); end
    checks++; if (cap_last !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", cap_last); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [7:0] d;
    d = 8'h55;
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data_out); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 400);
    checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL rstmid_no_strobe: got valid=%0d ferr=%0d want 0 0", n_valid - v0, n_ferr - f0); end
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 100);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_valid_count: got %0d want 1", n_valid - v0); end
    checks++; if (data_out !== 8'h81) begin errors++; $display("FAIL rstmid_data_after: got %h want 81", data_out); end
  endtask

  task automatic test_loopback();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    tx_write(8'h5A);
    repeat (200) @(negedge clk);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL loop_valid_count: got %0d want 1", n_valid - v0); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL loop_data: got %h want 5a", data_out); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL loop_ferr_count: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_strobe_shape();
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", n_overlap); end
    checks++; if (n_long !== 0) begin errors++; $display("FAIL strobe_width: got %0d long pulses want 0", n_long); end
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_strobe_shape();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
